// File: rtl/codebook_fill_seq.sv
// codebook_fill_seq: per-vector sequencer that issues centroid lines and tracks distance-table writes
module codebook_fill_seq #(
    parameter int W   = 32,
    parameter int Dt  = 8,
    parameter int Kt  = 32,
    parameter int Pt  = 16,
    parameter int LAT = 7,
    localparam int NL = Kt / Pt,
    localparam int AW = (NL > 1) ? $clog2(NL) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W*Dt-1:0] u_in,
    input  logic          u_vld,
    output logic          u_rdy,
    input  logic          hold,
    output logic [W*Dt-1:0] u,
    output logic          ena,
    output logic [AW-1:0] cent_addr,
    output logic          dist_wena,
    output logic [AW-1:0] dist_addr,
    output logic          tbl_vld,
    output logic          done
);
    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

    localparam logic [AW-1:0] LAST = AW'(NL - 1);

    state_t        state, state_nx;
    logic [AW-1:0] cnt;
    logic [LAT-1:0] sv;
    logic [AW-1:0] sa [LAT];
    logic          issue, accept, last_wr;

    assign cent_addr = cnt;
    assign dist_addr = sa[LAT-1];
    assign accept    = (state == IDLE) && u_vld;
    assign issue     = (state == FILL) && ena;
    assign last_wr   = (state == DRAIN) && dist_wena && (dist_addr == LAST);

    // next-state, handshake and pipeline-enable decode
    always_comb begin
        state_nx  = state;
        u_rdy     = (state == IDLE);
        ena       = (state == IDLE) || !hold;
        dist_wena = sv[LAT-1] && ena && (state != IDLE);
        case (state)
            IDLE:    state_nx = u_vld ? FILL : IDLE;
            FILL:    state_nx = (ena && cnt == LAST) ? DRAIN : FILL;
            DRAIN:   state_nx = last_wr ? IDLE : DRAIN;
            default: state_nx = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // captured vector, issue counter (parks on the last line), completion flags
    always_ff @(posedge clk) begin
        if (rst) begin
            u       <= '0;
            cnt     <= '0;
            tbl_vld <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= last_wr;
            if (accept) begin
                u       <= u_in;
                cnt     <= '0;
                tbl_vld <= 1'b0;
            end else begin
                if (issue && cnt != LAST) cnt <= cnt + AW'(1);
                if (last_wr) tbl_vld <= 1'b1;
            end
        end
    end

    // issue-valid/address delay line matching the RAM read plus distance pipe depth
    always_ff @(posedge clk) begin
        if (rst) begin
            sv <= '0;
            for (int i = 0; i < LAT; i++) sa[i] <= '0;
        end else if (ena) begin
            sv[0] <= issue;
            sa[0] <= cnt;
            for (int i = 1; i < LAT; i++) begin
                sv[i] <= sv[i-1];
                sa[i] <= sa[i-1];
            end
        end
    end
endmodule

// File: tb/tb_codebook_fill_seq.sv
// tb_codebook_fill_seq: scoreboard bench for the codebook fill sequencer
module tb_codebook_fill_seq;
    localparam int W = 32, Dt = 8, LAT = 7, NL = 2;

    logic clk = 0;
    logic rst = 1;
    always #5 clk = ~clk;

    logic [W*Dt-1:0] u_in, u, u1_in, u1;
    logic u_vld, hold, u_rdy, ena, dist_wena, tbl_vld, done;
    logic [0:0] cent_addr, dist_addr;
    logic u1_vld, u1_rdy, ena1, dist_wena1, tbl_vld1, done1;
    logic [0:0] cent_addr1, dist_addr1;

    codebook_fill_seq dut (
        .clk(clk), .rst(rst), .u_in(u_in), .u_vld(u_vld), .u_rdy(u_rdy), .hold(hold),
        .u(u), .ena(ena), .cent_addr(cent_addr), .dist_wena(dist_wena),
        .dist_addr(dist_addr), .tbl_vld(tbl_vld), .done(done)
    );

    codebook_fill_seq #(.Kt(16), .Pt(16)) dut1 (
        .clk(clk), .rst(rst), .u_in(u1_in), .u_vld(u1_vld), .u_rdy(u1_rdy), .hold(1'b0),
        .u(u1), .ena(ena1), .cent_addr(cent_addr1), .dist_wena(dist_wena1),
        .dist_addr(dist_addr1), .tbl_vld(tbl_vld1), .done(done1)
    );

    int checks = 0, errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // reference model: rem counts the enabled cycles left before the sequencer is idle again
    int rem = 0, m_last = 0, acc = 0, aborted = 0, dones = 0;
    logic m_tbl = 0, m_done = 0;
    logic [255:0] m_u = '0;
    int q[$];
    int wcyc[$];
    int acyc[$];
    int dcyc = -1;
    bit live = 0;

    always @(posedge clk) begin
        if (rst) begin
            if (rem != 0) aborted <= aborted + 1;
            rem <= 0; m_tbl <= 0; m_done <= 0; m_u <= '0; m_last <= 0;
            q.delete();
        end else begin
            m_done <= 0;
            if (rem == 0 && u_vld) begin
                rem <= NL + LAT; m_tbl <= 0; m_u <= u_in; acc <= acc + 1;
                for (int i = 0; i < NL; i++) q.push_back(i);
            end else if (rem != 0 && !hold) begin
                rem <= rem - 1;
                if (rem == 1) begin m_tbl <= 1; m_done <= 1; m_last <= NL - 1; end
            end
        end
    end

    always @(negedge clk) begin
        if (live) begin : mon
            int ea;
            bit idle, ew;
            idle = (rem == 0);
            ew = !idle && !hold && rem <= NL;
            ea = rem > LAT ? NL + LAT - rem : (idle ? m_last : NL - 1);
            check("u_rdy", u_rdy, idle);
            check("ena", ena, idle || !hold);
            check("dist_wena", dist_wena, ew);
            check("done", done, m_done);
            check("tbl_vld", tbl_vld, m_tbl);
            check("u", u, m_u);
            check("cent_addr", cent_addr, ea);
            if (u_vld && u_rdy) acyc.push_back(cyc);
            if (dist_wena) begin
                wcyc.push_back(cyc);
                if (q.size() == 0) check("sb_extra_write", 1, 0);
                else check("sb_addr", dist_addr, q.pop_front());
            end
            if (done) begin dones++; dcyc = cyc; end
        end
    end

    int w1 = 0, w1cyc = -1, d1 = 0, d1cyc = -1;
    logic [0:0] w1addr = 0;
    always @(negedge clk) begin
        if (live) begin
            if (dist_wena1) begin
                w1++; w1cyc = cyc; w1addr = dist_addr1;
                check("nl1_wr_in_idle", u1_rdy, 0);
            end
            if (done1) begin d1++; d1cyc = cyc; end
        end
    end

    initial begin
        int c0;
        u_in = '0; u_vld = 0; hold = 0; u1_in = '0; u1_vld = 0;
        rst = 1;
        step(); step();
        live = 1;
        check("rst_u", u, 0);
        check("rst_cent_addr", cent_addr, 0);
        check("rst_dist_wena", dist_wena, 0);
        check("rst_tbl_vld", tbl_vld, 0);
        check("rst_done", done, 0);
        check("rst_u_rdy", u_rdy, 1);
        check("rst_nl1_tbl_vld", tbl_vld1, 0);
        rst = 0;
        step();

        // single vector, no stall
        u_in = {8{$urandom}}; u_vld = 1; c0 = cyc; wcyc.delete();
        step(); u_vld = 0;
        repeat (14) step();
        check("basic_nwr", wcyc.size(), 2);
        if (wcyc.size() == 2) begin
            check("basic_wr0_cyc", wcyc[0], c0 + 8);
            check("basic_wr1_cyc", wcyc[1], c0 + 9);
        end
        check("basic_done_cyc", dcyc, c0 + 10);

        // hold during cycles 4..6
        u_in = {8{$urandom}}; u_vld = 1; c0 = cyc; wcyc.delete();
        step(); u_vld = 0;
        repeat (3) step(); hold = 1;
        repeat (3) step(); hold = 0;
        repeat (10) step();
        check("hold_nwr", wcyc.size(), 2);
        if (wcyc.size() == 2) begin
            check("hold_wr0_cyc", wcyc[0], c0 + 11);
            check("hold_wr1_cyc", wcyc[1], c0 + 12);
        end
        check("hold_done_cyc", dcyc, c0 + 13);

        // reset in cycle 5 of a fill, then a clean fill
        u_in = {8{$urandom}}; u_vld = 1;
        step(); u_vld = 0;
        repeat (4) step(); rst = 1;
        step(); rst = 0; wcyc.delete();
        repeat (12) step();
        check("rst_mid_nwr", wcyc.size(), 0);
        check("rst_mid_tbl_vld", tbl_vld, 0);
        check("rst_mid_u", u, 0);
        u_in = {8{$urandom}}; u_vld = 1; c0 = cyc;
        step(); u_vld = 0;
        repeat (14) step();
        check("post_rst_nwr", wcyc.size(), 2);
        check("post_rst_tbl_vld", tbl_vld, 1);

        // continuous u_vld with changing u_in
        acyc.delete(); u_vld = 1;
        for (int i = 0; i < 45; i++) begin
            u_in = {8{$urandom}};
            step();
        end
        u_vld = 0;
        check("stream_nacc", acyc.size(), 5);
        for (int i = 1; i < acyc.size(); i++) check("stream_spacing", acyc[i] - acyc[i-1], NL + LAT + 1);

        // random valid/hold traffic
        for (int i = 0; i < 400; i++) begin
            u_in = {8{$urandom}};
            u_vld = ($urandom_range(0, 3) == 0);
            hold = ($urandom_range(0, 4) == 0);
            step();
        end
        u_vld = 0; hold = 0;
        for (int i = 0; i < 40 && rem != 0; i++) step();
        step(); step();
        check("drain_idle", rem, 0);
        check("sb_left", q.size(), 0);
        check("done_count", dones, acc - aborted);

        // NL = 1 instance
        u1_in = {8{$urandom}}; u1_vld = 1; c0 = cyc;
        step(); u1_vld = 0;
        repeat (12) step();
        check("nl1_nwr", w1, 1);
        check("nl1_wr_cyc", w1cyc, c0 + 1 + LAT);
        check("nl1_wr_addr", w1addr, 0);
        check("nl1_ndone", d1, 1);
        check("nl1_done_cyc", d1cyc, c0 + LAT + 2);
        check("nl1_tbl_vld", tbl_vld1, 1);
        check("nl1_u", u1, u1_in);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/codebook_fill_seq.md
CODEBOOK_FILL_SEQ -- requirements
Module: codebook_fill_seq

Interface
REQ-001 Parameter: W, 32, datawidth.
REQ-002 Parameter: Dt, 8, subspace dimension.
REQ-003 Parameter: Kt, 32, PQ codebook size.
REQ-004 Parameter: Pt, 16, codebook-update parallelism; NL = Kt/Pt distance lines, Kt divisible by Pt, NL >= 1.
REQ-005 Parameter: LAT, 7, cycles from cent_addr issue to squared distances valid at the distance RAM write port (1 RAM read + 3+log2(Dt) squared-distance pipe).
REQ-006 Port: clk  input  1  global clock, all state on rising edge.
REQ-007 Port: rst  input  1  reset, synchronous, active-high.
REQ-008 Port: u_in  input  W*Dt  new subspace vector.
REQ-009 Port: u_vld  input  1  u_in valid.
REQ-010 Port: u_rdy  output  1  vector accepted when u_vld && u_rdy.
REQ-011 Port: hold  input  1  downstream stall request.
REQ-012 Port: u  output  W*Dt  registered vector driven to the squared-distance array.
REQ-013 Port: ena  output  1  register enable for the squared-distance pipeline.
REQ-014 Port: cent_addr  output  log2(NL)  centroid RAM line address (1 bit wide when NL = 1).
REQ-015 Port: dist_wena  output  1  distance RAM write enable.
REQ-016 Port: dist_addr  output  log2(NL)  distance RAM write line.
REQ-017 Port: tbl_vld  output  1  distance table complete for the current u.
REQ-018 Port: done  output  1  one-cycle pulse on table completion.

Function
REQ-019 The block SHALL implement states IDLE, FILL, DRAIN.
- IDLE: u_rdy = 1.
- IDLE -> FILL on u_vld: u <= u_in, tbl_vld <= 0, issue counter <= 0.
REQ-020 In FILL, when ena = 1, cent_addr SHALL equal the issue counter, and the counter SHALL increment by one per cycle over 0..NL-1.
REQ-021 FILL SHALL go to DRAIN in the cycle it issues line NL-1.
REQ-022 A LAT-deep shift register SHALL carry {issue-valid, address}, advancing only when ena = 1.
- Its output drives dist_wena and dist_addr.
- dist_wena therefore asserts exactly LAT enabled cycles after each issue, with the matching address.
REQ-023 ena SHALL equal !hold whenever the state is not IDLE, and 1 in IDLE.
- While hold = 1: counter, shift register, state and dist_wena are frozen, and dist_wena is forced 0.
REQ-024 DRAIN SHALL go to IDLE on the cycle the write of line NL-1 occurs.
- Same edge: tbl_vld <= 1, done pulses for exactly 1 cycle.
REQ-025 Exactly NL writes SHALL occur per accepted vector, addresses 0..NL-1 in ascending order, none repeated.
REQ-026 u SHALL remain stable from acceptance until the state returns to IDLE; u_rdy = 0 in FILL and DRAIN.
REQ-027 A u_vld arriving in the same cycle that DRAIN -> IDLE SHALL NOT be accepted until the following cycle.
- Minimum vector-to-vector spacing: NL+LAT+1 cycles.
REQ-028 NL = 1: FILL SHALL last one cycle, and a single write SHALL occur at address 0.
REQ-029 cent_addr SHALL hold its last value outside FILL.
REQ-030 dist_wena SHALL never assert in IDLE.

Reset
REQ-031 rst SHALL force, on the next rising edge:
- state = IDLE;
- u = 0, cent_addr = 0, dist_addr = 0, counter = 0, shift register cleared;
- dist_wena = 0, tbl_vld = 0, done = 0.
REQ-032 rst SHALL take priority over u_vld and hold.
REQ-033 rst asserted mid-FILL or mid-DRAIN SHALL suppress every in-flight write; no dist_wena after reset until a new vector is accepted.

Verification
REQ-034 Defaults (NL = 2, LAT = 7), u_vld at cycle 0:
- cent_addr 0 at cycle 1, 1 at cycle 2;
- dist_wena at cycles 8 and 9, dist_addr 0 then 1;
- done and tbl_vld rise at cycle 10.
REQ-035 Same stimulus with hold = 1 for cycles 4-6:
- writes shift to cycles 11 and 12;
- ena = 0 and dist_wena = 0 during the hold.
REQ-036 rst pulse at cycle 5 of a fill:
- no dist_wena afterwards;
- tbl_vld = 0, u = 0;
- the next vector produces a clean 2-write fill.
REQ-037 u_vld held continuously with changing u_in:
- acceptances spaced 10 cycles apart;
- u constant during each fill;
- tbl_vld drops on each acceptance.
REQ-038 Kt = 16, Pt = 16 (NL = 1):
- a single write at address 0, LAT cycles after issue;
- a one-cycle done pulse.
REQ-039 Random u_vld/hold with a scoreboard:
- per vector, the NL writes occur in ascending order;
- never a write in IDLE;
- done count equals acceptance count.
